// File: rtl/l0_readout_queue.sv
// L0 readout request queue: buffers pre-increment L0IDs on each readout
// strobe and hands them to the readout sequencer in FIFO order.
module l0_readout_queue #(
  parameter int RO_ADDR_WIDTH = 8,
  parameter int QDEPTH        = 8
) (
  input  logic                       CLK,
  input  logic                       SoftResetB,
  input  logic                       ROReadStrob,
  input  logic [RO_ADDR_WIDTH-1:0]   L0ID_Local,
  input  logic                       FlushQ,
  input  logic                       ClearOvf,
  input  logic                       ReqReady,
  output logic                       ReqValid,
  output logic [RO_ADDR_WIDTH-1:0]   ReqL0ID,
  output logic                       QEmpty,
  output logic                       QFull,
  output logic [$clog2(QDEPTH):0]    QLevel,
  output logic                       Overflow,
  output logic [3:0]                 DropCount
);

  localparam int AW = $clog2(QDEPTH);
  localparam logic [AW:0] DEPTH = QDEPTH[AW:0];

  logic [RO_ADDR_WIDTH-1:0] mem_q [QDEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   lvl_q, lvl_d;
  logic          ovf_q, ovf_d;
  logic [3:0]    cnt_q, cnt_d;

  logic empty, full, pop, push, drop;

  assign empty = (lvl_q == '0);
  assign full  = (lvl_q == DEPTH);
  assign pop   = ReqReady && !empty && !FlushQ;
  assign push  = ROReadStrob && !FlushQ && (!full || pop);
  assign drop  = ROReadStrob && !FlushQ && full && !pop;

  // Next-state for pointers, occupancy and drop bookkeeping.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    lvl_d  = lvl_q;
    ovf_d  = ovf_q;
    cnt_d  = cnt_q;
    if (FlushQ) begin
      wptr_d = '0;
      rptr_d = '0;
      lvl_d  = '0;
    end else begin
      if (push) wptr_d = wptr_q + 1'b1;
      if (pop)  rptr_d = rptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   lvl_d = lvl_q + 1'b1;
        2'b01:   lvl_d = lvl_q - 1'b1;
        default: lvl_d = lvl_q;
      endcase
    end
    if (ClearOvf) begin
      ovf_d = drop;
      cnt_d = {3'b000, drop};
    end else if (drop) begin
      ovf_d = 1'b1;
      if (cnt_q != 4'hF) cnt_d = cnt_q + 4'd1;
    end
  end

  // Control state register with asynchronous clear.
  always_ff @(posedge CLK or negedge SoftResetB) begin
    if (!SoftResetB) begin
      wptr_q <= '0;
      rptr_q <= '0;
      lvl_q  <= '0;
      ovf_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      lvl_q  <= lvl_d;
      ovf_q  <= ovf_d;
      cnt_q  <= cnt_d;
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wptr_q] <= L0ID_Local;
  end

  assign ReqValid  = !empty;
  assign ReqL0ID   = empty ? '0 : mem_q[rptr_q];
  assign QEmpty    = empty;
  assign QFull     = full;
  assign QLevel    = lvl_q;
  assign Overflow  = ovf_q;
  assign DropCount = cnt_q;

endmodule

// File: tb/tb_l0_readout_queue.sv
// Directed bench for l0_readout_queue: vector table plus
// hand sequences for wrap, overflow, flush and async reset.
module tb_l0_readout_queue;

  logic       CLK = 1'b0;
  logic       SoftResetB;
  logic       ROReadStrob;
  logic [7:0] L0ID_Local;
  logic       FlushQ;
  logic       ClearOvf;
  logic       ReqReady;
  logic       ReqValid;
  logic [7:0] ReqL0ID;
  logic       QEmpty;
  logic       QFull;
  logic [3:0] QLevel;
  logic       Overflow;
  logic [3:0] DropCount;

  int checks = 0;
  int failures = 0;

  l0_readout_queue #(.RO_ADDR_WIDTH(8), .QDEPTH(8)) dut (
    .CLK(CLK), .SoftResetB(SoftResetB), .ROReadStrob(ROReadStrob),
    .L0ID_Local(L0ID_Local), .FlushQ(FlushQ), .ClearOvf(ClearOvf),
    .ReqReady(ReqReady), .ReqValid(ReqValid), .ReqL0ID(ReqL0ID),
    .QEmpty(QEmpty), .QFull(QFull), .QLevel(QLevel),
    .Overflow(Overflow), .DropCount(DropCount)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       stb;
    logic [7:0] id;
    logic       rdy;
    logic       fl;
    logic       clr;
    logic       e_val;
    logic [7:0] e_id;
    logic [3:0] e_lvl;
    logic       e_full;
    logic       e_ovf;
    logic [3:0] e_cnt;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    ROReadStrob = 0; FlushQ = 0; ClearOvf = 0; ReqReady = 0;
  endtask

  task automatic chk_state(input string nm, input logic v,
                           input logic [7:0] id, input logic [3:0] lv,
                           input logic f, input logic o,
                           input logic [3:0] c);
    chk({nm, ".valid"}, int'(ReqValid), int'(v));
    chk({nm, ".empty"}, int'(QEmpty), int'(!v));
    chk({nm, ".l0id"}, int'(ReqL0ID), int'(id));
    chk({nm, ".level"}, int'(QLevel), int'(lv));
    chk({nm, ".full"}, int'(QFull), int'(f));
    chk({nm, ".ovf"}, int'(Overflow), int'(o));
    chk({nm, ".drops"}, int'(DropCount), int'(c));
  endtask

  initial begin
    //       stb  id     rdy fl clr val id    lvl full ovf cnt
    vt[0] = '{1, 8'hFF, 0, 0, 0, 1, 8'hFF, 1, 0, 0, 0};
    vt[1] = '{0, 8'h00, 0, 0, 0, 1, 8'hFF, 1, 0, 0, 0};
    vt[2] = '{0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0};
    vt[3] = '{0, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0};
    vt[4] = '{1, 8'h10, 1, 0, 0, 1, 8'h10, 1, 0, 0, 0};
    vt[5] = '{1, 8'h11, 1, 0, 0, 1, 8'h11, 1, 0, 0, 0};
    vt[6] = '{1, 8'h12, 0, 0, 0, 1, 8'h11, 2, 0, 0, 0};
    vt[7] = '{1, 8'h13, 0, 0, 0, 1, 8'h11, 3, 0, 0, 0};
    vt[8] = '{1, 8'h14, 1, 1, 0, 0, 8'h00, 0, 0, 0, 0};

    idle();
    L0ID_Local = 0;
    SoftResetB = 0;
    #12;
    chk_state("reset", 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    SoftResetB = 1;
    #1;

    for (int i = 0; i < 9; i++) begin
      ROReadStrob = vt[i].stb;
      L0ID_Local  = vt[i].id;
      ReqReady    = vt[i].rdy;
      FlushQ      = vt[i].fl;
      ClearOvf    = vt[i].clr;
      step();
      chk_state($sformatf("vec%0d", i), vt[i].e_val, vt[i].e_id,
                vt[i].e_lvl, vt[i].e_full, vt[i].e_ovf, vt[i].e_cnt);
    end
    idle();

    // Burst of 20 with ready held high: pointers wrap twice
    ReqReady = 1;
    for (int k = 0; k < 20; k++) begin
      ROReadStrob = 1;
      L0ID_Local  = 8'(k);
      step();
      chk($sformatf("burst.head%0d", k), int'(ReqL0ID), k);
    end
    ROReadStrob = 0;
    step();
    chk("burst.empty", int'(QEmpty), 1);
    chk("burst.ovf", int'(Overflow), 0);
    idle();

    // Overflow: 11 strobes into depth 8
    for (int k = 0; k < 11; k++) begin
      ROReadStrob = 1;
      L0ID_Local  = 8'h20 + 8'(k);
      step();
    end
    ROReadStrob = 0;
    chk_state("ovf", 1, 8'h20, 8, 1, 1, 3);

    // Full with simultaneous push and pop
    ROReadStrob = 1; L0ID_Local = 8'h40; ReqReady = 1;
    step();
    ROReadStrob = 0; ReqReady = 0;
    chk_state("fullpp", 1, 8'h21, 8, 1, 1, 3);

    for (int k = 0; k < 8; k++) begin
      chk($sformatf("drain%0d", k), int'(ReqL0ID),
          (k < 7) ? 'h21 + k : 'h40);
      ReqReady = 1;
      step();
    end
    ReqReady = 0;
    chk_state("drained", 0, 0, 0, 0, 1, 3);

    ClearOvf = 1;
    step();
    ClearOvf = 0;
    chk_state("clear", 0, 0, 0, 0, 0, 0);

    // Fill, then drop coinciding with clear
    for (int k = 0; k < 8; k++) begin
      ROReadStrob = 1; L0ID_Local = 8'h60 + 8'(k);
      step();
    end
    ClearOvf = 1; L0ID_Local = 8'h70;
    step();
    ClearOvf = 0;
    chk_state("dropclr", 1, 8'h60, 8, 1, 1, 1);

    // Saturate the drop counter
    for (int k = 0; k < 20; k++) step();
    ROReadStrob = 0;
    chk("sat.drops", int'(DropCount), 15);

    // Flush at full with strobe: no drop counted, sticky kept
    FlushQ = 1; ROReadStrob = 1;
    step();
    idle();
    chk_state("flushfull", 0, 0, 0, 0, 1, 15);

    // Level 5 then flush with strobe
    for (int k = 0; k < 5; k++) begin
      ROReadStrob = 1; L0ID_Local = 8'h80 + 8'(k);
      step();
    end
    chk("lvl5", int'(QLevel), 5);
    FlushQ = 1;
    step();
    idle();
    chk_state("flush5", 0, 0, 0, 0, 1, 15);
    ClearOvf = 1;
    step();
    ClearOvf = 0;
    chk_state("clear2", 0, 0, 0, 0, 0, 0);

    // Async reset mid-operation
    for (int k = 0; k < 4; k++) begin
      ROReadStrob = 1; L0ID_Local = 8'h90 + 8'(k);
      step();
    end
    ROReadStrob = 0;
    chk("pre_rst.lvl", int'(QLevel), 4);
    #2;
    SoftResetB = 0;
    #1;
    chk_state("async_rst", 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    SoftResetB = 1;
    ROReadStrob = 1; L0ID_Local = 8'h55;
    step();
    ROReadStrob = 0;
    chk_state("post_rst", 1, 8'h55, 1, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
